// File: rtl/interrupt_ctrl.sv
// Wishbone-slave interrupt controller: SOFT/TIMER bits plus N_SRC prioritised external sources.
// Define INT_SYNC_EN to pass irq_src through a 2-flop synchroniser before sampling.
module interrupt_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       int_addr,
    input  logic [31:0]      int_dat_w,
    input  logic [3:0]       int_sel,
    input  logic             int_cyc,
    input  logic             int_stb,
    input  logic [2:0]       int_cti,
    input  logic [1:0]       int_bte,
    input  logic             int_we,
    output logic [31:0]      int_dat_r,
    output logic             int_ack,
    output logic             int_err,
    input  logic [N_SRC-1:0] irq_src,
    output logic             external_interrupt,
    output logic             timer_interrupt,
    output logic             software_interrupt
);

    localparam logic [3:0] IDX_SOFT    = 4'd0;
    localparam logic [3:0] IDX_TIMER   = 4'd1;
    localparam logic [3:0] IDX_PENDING = 4'd2;
    localparam logic [3:0] IDX_ENABLE  = 4'd3;
    localparam logic [3:0] IDX_EDGE    = 4'd4;
    localparam logic [3:0] IDX_CLAIM   = 4'd5;

    // Sampled view of the sources and its one-cycle history for edge detection
    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] prev_q;

`ifdef INT_SYNC_EN
    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    logic             soft_q, soft_d;
    logic             timer_q, timer_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      dat_r_q, dat_r_d;
    logic             ext_q, ext_d;

    // Request captured in the request cycle, applied in the ack cycle
    logic             wr_q, wr_d;
    logic [3:0]       wr_idx_q, wr_idx_d;
    logic [N_SRC-1:0] wr_data_q, wr_data_d;
    logic             clr_q, clr_d;
    logic [4:0]       clr_k_q, clr_k_d;

    logic       req_take;
    logic [3:0] req_idx;
    logic       req_mapped;

    assign req_take   = int_cyc & int_stb & ~ack_q & ~err_q;
    assign req_idx    = int_addr[5:2];
    assign req_mapped = (req_idx <= IDX_CLAIM);

    // Lowest-index enabled pending source wins the claim
    logic        claim_hit;
    logic [4:0]  claim_k;
    logic [31:0] claim_val;

    always_comb begin
        claim_hit = 1'b0;
        claim_k   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending_q[i] && enable_q[i]) begin
                claim_hit = 1'b1;
                claim_k   = 5'(i);
            end
        end
    end

    assign claim_val = claim_hit ? {27'd0, claim_k + 5'd1} : 32'd0;

    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (req_idx)
            IDX_SOFT:    rd_data[0]         = soft_q;
            IDX_TIMER:   rd_data[0]         = timer_q;
            IDX_PENDING: rd_data[N_SRC-1:0] = pending_q;
            IDX_ENABLE:  rd_data[N_SRC-1:0] = enable_q;
            IDX_EDGE:    rd_data[N_SRC-1:0] = edge_q;
            IDX_CLAIM:   rd_data            = claim_val;
            default:     rd_data            = '0;
        endcase
    end

    always_comb begin
        ack_d     = req_take & req_mapped;
        err_d     = req_take & ~req_mapped;
        dat_r_d   = (req_take && req_mapped) ? rd_data : 32'd0;
        wr_d      = req_take & req_mapped & int_we & (int_sel == 4'b1111);
        wr_idx_d  = req_idx;
        wr_data_d = int_dat_w[N_SRC-1:0];
        clr_d     = req_take & ~int_we & (req_idx == IDX_CLAIM) & claim_hit;
        clr_k_d   = claim_k;
    end

    logic wr_en;
    logic wr_soft, wr_timer, wr_pend, wr_enable, wr_edge;
    logic claim_clr_en;

    assign wr_en        = ack_q & wr_q;
    assign wr_soft      = wr_en & (wr_idx_q == IDX_SOFT);
    assign wr_timer     = wr_en & (wr_idx_q == IDX_TIMER);
    assign wr_pend      = wr_en & (wr_idx_q == IDX_PENDING);
    assign wr_enable    = wr_en & (wr_idx_q == IDX_ENABLE);
    assign wr_edge      = wr_en & (wr_idx_q == IDX_EDGE);
    assign claim_clr_en = ack_q & clr_q;

    always_comb begin
        soft_d   = wr_soft   ? wr_data_q[0] : soft_q;
        timer_d  = wr_timer  ? wr_data_q[0] : timer_q;
        enable_d = wr_enable ? wr_data_q    : enable_q;
        edge_d   = wr_edge   ? wr_data_q    : edge_q;
        ext_d    = |(pending_q & enable_q);
    end

    logic [N_SRC-1:0] mode_chg;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] claim_clr;

    assign mode_chg = wr_edge ? (wr_data_q ^ edge_q) : '0;
    assign w1c      = wr_pend ? wr_data_q : '0;

    // A fresh edge beats any clear landing in the same cycle; a mode change always clears
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign rise[gi]      = src_s[gi] & ~prev_q[gi];
            assign claim_clr[gi] = claim_clr_en & (clr_k_q == 5'(gi));
            assign pending_d[gi] = mode_chg[gi] ? 1'b0 :
                                   edge_q[gi]   ? (rise[gi] | (pending_q[gi] & ~w1c[gi] & ~claim_clr[gi])) :
                                                  src_s[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            soft_q    <= 1'b0;
            timer_q   <= 1'b0;
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            prev_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_r_q   <= '0;
            ext_q     <= 1'b0;
            wr_q      <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            clr_q     <= 1'b0;
            clr_k_q   <= '0;
        end else begin
            soft_q    <= soft_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            prev_q    <= src_s;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_r_q   <= dat_r_d;
            ext_q     <= ext_d;
            wr_q      <= wr_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            clr_q     <= clr_d;
            clr_k_q   <= clr_k_d;
        end
    end

    assign int_dat_r          = dat_r_q;
    assign int_ack            = ack_q;
    assign int_err            = err_q;
    assign external_interrupt = ext_q;
    assign timer_interrupt    = timer_q;
    assign software_interrupt = soft_q;

    // Burst hints and byte-lane address bits carry no meaning for single-beat registers
    logic unused_ok;
    assign unused_ok = ^{int_cti, int_bte, int_addr[1:0], int_dat_w};

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed scenarios plus randomized register/source traffic
// checked against an event-level model of the pending/enable/edge rules.
module tb_interrupt_ctrl;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_addr;
    logic [31:0] int_dat_w;
    logic [3:0]  int_sel;
    logic        int_cyc;
    logic        int_stb;
    logic [2:0]  int_cti;
    logic [1:0]  int_bte;
    logic        int_we;
    logic [31:0] int_dat_r;
    logic        int_ack;
    logic        int_err;
    logic [N-1:0] irq_src;
    logic        external_interrupt;
    logic        timer_interrupt;
    logic        software_interrupt;

    always #5 clk = ~clk;

    interrupt_ctrl #(.N_SRC(N)) dut (
        .clk                (clk),
        .rst                (rst),
        .int_addr           (int_addr),
        .int_dat_w          (int_dat_w),
        .int_sel            (int_sel),
        .int_cyc            (int_cyc),
        .int_stb            (int_stb),
        .int_cti            (int_cti),
        .int_bte            (int_bte),
        .int_we             (int_we),
        .int_dat_r          (int_dat_r),
        .int_ack            (int_ack),
        .int_err            (int_err),
        .irq_src            (irq_src),
        .external_interrupt (external_interrupt),
        .timer_interrupt    (timer_interrupt),
        .software_interrupt (software_interrupt)
    );

    localparam logic [3:0] R_SOFT = 4'd0, R_TIMER = 4'd1, R_PEND = 4'd2,
                           R_EN = 4'd3, R_EDGE = 4'd4, R_CLAIM = 4'd5;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rd;
    logic        ak, er;
    logic [7:0]  m_pend, m_en, m_edge, m_src;

    task automatic bus(input logic we, input logic [3:0] idx, input logic [31:0] data,
                       input logic [3:0] sel, output logic [31:0] rdata,
                       output logic ack_seen, output logic err_seen);
        @(negedge clk);
        int_cyc   = 1'b1;
        int_stb   = 1'b1;
        int_we    = we;
        int_addr  = {idx, 2'b00};
        int_dat_w = data;
        int_sel   = sel;
        int_cti   = 3'($urandom_range(0, 7));
        int_bte   = 2'($urandom_range(0, 3));
        ack_seen  = 1'b0;
        err_seen  = 1'b0;
        rdata     = '0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            if (int_ack || int_err) begin
                ack_seen = int_ack;
                err_seen = int_err;
                rdata    = int_dat_r;
                break;
            end
        end
        $display("bus we=%0d idx=%0d wdata=%h sel=%b rdata=%h ack=%0b err=%0b",
                 we, idx, data, sel, rdata, ack_seen, err_seen);
        @(negedge clk);
        int_cyc = 1'b0;
        int_stb = 1'b0;
        int_we  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        @(negedge clk);
        irq_src = v;
        @(negedge clk);
        irq_src = 8'h00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Model update: edge bits latch a rising source, level bits mirror the source
    task automatic set_src(input logic [7:0] v);
        @(negedge clk);
        irq_src = v;
        m_pend  = ((m_pend | (v & ~m_src)) & m_edge) | (v & ~m_edge);
        m_src   = v;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; int_cyc = 0; int_stb = 0; int_we = 0; int_addr = '0;
        int_dat_w = '0; int_sel = '0; int_cti = '0; int_bte = '0; irq_src = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({int_ack, int_err, int_dat_r, external_interrupt, timer_interrupt, software_interrupt} !== 37'd0)
            $display("FAIL reset_outputs: got ack=%b err=%b dat=%h ext=%b tmr=%b sw=%b want all 0",
                     int_ack, int_err, int_dat_r, external_interrupt, timer_interrupt, software_interrupt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus(1'b0, 4'(i), 32'd0, 4'hf, rd, ak, er);
            n_checks++;
            if (rd !== 32'd0 || ak !== 1'b1 || er !== 1'b0)
                $display("FAIL reset_read_%0d: got data=%h ack=%b err=%b want data=0 ack=1 err=0", i, rd, ak, er);
            else n_pass++;
        end
        bus(1'b0, 4'd7, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (er !== 1'b1 || ak !== 1'b0)
            $display("FAIL unmapped_err: got ack=%b err=%b want ack=0 err=1", ak, er);
        else n_pass++;
        bus(1'b1, 4'd12, 32'hffff_ffff, 4'hf, rd, ak, er);
        n_checks++;
        if (er !== 1'b1 || ak !== 1'b0 || software_interrupt !== 1'b0 || timer_interrupt !== 1'b0)
            $display("FAIL unmapped_write: got ack=%b err=%b sw=%b tmr=%b want ack=0 err=1 sw=0 tmr=0",
                     ak, er, software_interrupt, timer_interrupt);
        else n_pass++;
    endtask

    task automatic test_soft_timer();
        bus(1'b1, R_SOFT, 32'd1, 4'hf, rd, ak, er);
        n_checks++;
        if (ak !== 1'b1 || software_interrupt !== 1'b1)
            $display("FAIL soft_write: got ack=%b sw=%b want ack=1 sw=1", ak, software_interrupt);
        else n_pass++;
        bus(1'b1, R_TIMER, 32'd1, 4'b0011, rd, ak, er);
        n_checks++;
        if (ak !== 1'b1 || timer_interrupt !== 1'b0)
            $display("FAIL timer_partial: got ack=%b tmr=%b want ack=1 tmr=0", ak, timer_interrupt);
        else n_pass++;
        bus(1'b1, R_TIMER, 32'hffff_ffff, 4'hf, rd, ak, er);
        bus(1'b0, R_TIMER, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'd1 || timer_interrupt !== 1'b1)
            $display("FAIL timer_full: got data=%h tmr=%b want data=00000001 tmr=1", rd, timer_interrupt);
        else n_pass++;
        bus(1'b1, R_SOFT, 32'd0, 4'hf, rd, ak, er);
        bus(1'b1, R_TIMER, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (software_interrupt !== 1'b0 || timer_interrupt !== 1'b0)
            $display("FAIL soft_timer_clear: got sw=%b tmr=%b want 0 0", software_interrupt, timer_interrupt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        logic [5:0] want;
        @(negedge clk);
        int_cyc = 1'b1; int_stb = 1'b1; int_we = 1'b0; int_addr = {R_SOFT, 2'b00}; int_sel = 4'hf;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            seen[c] = int_ack;
            want[c] = (c % 2 == 0);
        end
        $display("bus held strobe ack pattern=%b", seen);
        @(negedge clk);
        int_cyc = 1'b0; int_stb = 1'b0;
        repeat (3) @(posedge clk);
        n_checks++;
        if (seen !== want)
            $display("FAIL held_strobe: got ack pattern %b want %b", seen, want);
        else n_pass++;
    endtask

    task automatic test_edge_claim();
        bus(1'b1, R_EDGE, 32'h08, 4'hf, rd, ak, er);
        bus(1'b1, R_EN, 32'h08, 4'hf, rd, ak, er);
        pulse(8'h08);
        bus(1'b0, R_PEND, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'h08 || external_interrupt !== 1'b1)
            $display("FAIL edge_pending: got pend=%h ext=%b want pend=00000008 ext=1", rd, external_interrupt);
        else n_pass++;
        bus(1'b0, R_CLAIM, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'd4)
            $display("FAIL edge_claim: got %h want 00000004", rd);
        else n_pass++;
        bus(1'b0, R_PEND, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'd0 || external_interrupt !== 1'b0)
            $display("FAIL edge_claim_clear: got pend=%h ext=%b want pend=0 ext=0", rd, external_interrupt);
        else n_pass++;
    endtask

    task automatic test_level();
        bus(1'b1, R_EDGE, 32'h00, 4'hf, rd, ak, er);
        bus(1'b1, R_EN, 32'h02, 4'hf, rd, ak, er);
        @(negedge clk);
        irq_src = 8'h02;
        for (int r = 0; r < 2; r++) begin
            bus(1'b0, R_CLAIM, 32'd0, 4'hf, rd, ak, er);
            n_checks++;
            if (rd !== 32'd2)
                $display("FAIL level_claim_%0d: got %h want 00000002", r, rd);
            else n_pass++;
        end
        bus(1'b1, R_PEND, 32'h02, 4'hf, rd, ak, er);
        bus(1'b0, R_PEND, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'h02 || external_interrupt !== 1'b1)
            $display("FAIL level_w1c: got pend=%h ext=%b want pend=00000002 ext=1", rd, external_interrupt);
        else n_pass++;
        @(negedge clk);
        irq_src = 8'h00;
        @(posedge clk);
        #1;
        n_checks++;
        if (external_interrupt !== 1'b1)
            $display("FAIL level_drop_ext_hold: got ext=%b want 1", external_interrupt);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (external_interrupt !== 1'b0)
            $display("FAIL level_drop_ext_clear: got ext=%b want 0", external_interrupt);
        else n_pass++;
        bus(1'b0, R_PEND, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'd0)
            $display("FAIL level_drop_pend: got %h want 0", rd);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [31:0] want [3];
        want = '{32'd3, 32'd6, 32'd0};
        bus(1'b1, R_EN, 32'h24, 4'hf, rd, ak, er);
        bus(1'b1, R_EDGE, 32'h24, 4'hf, rd, ak, er);
        pulse(8'h24);
        for (int r = 0; r < 3; r++) begin
            bus(1'b0, R_CLAIM, 32'd0, 4'hf, rd, ak, er);
            n_checks++;
            if (rd !== want[r])
                $display("FAIL prio_claim_%0d: got %h want %h", r, rd, want[r]);
            else n_pass++;
        end
        pulse(8'h24);
        bus(1'b1, R_EN, 32'h20, 4'hf, rd, ak, er);
        bus(1'b0, R_CLAIM, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'd6)
            $display("FAIL prio_disabled: got %h want 00000006", rd);
        else n_pass++;
        bus(1'b0, R_PEND, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'h04)
            $display("FAIL prio_disabled_pend: got %h want 00000004", rd);
        else n_pass++;
    endtask

    task automatic test_w1c_collision();
        bus(1'b1, R_EDGE, 32'h01, 4'hf, rd, ak, er);
        bus(1'b1, R_EN, 32'h01, 4'hf, rd, ak, er);
        pulse(8'h01);
        bus(1'b1, R_PEND, 32'h01, 4'hf, rd, ak, er);
        bus(1'b0, R_PEND, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'd0)
            $display("FAIL w1c_plain: got %h want 0", rd);
        else n_pass++;
        pulse(8'h01);
        // W1C lands at the end of the ack cycle; raise the source so its edge is seen at that same edge
        @(negedge clk);
        int_cyc = 1'b1; int_stb = 1'b1; int_we = 1'b1; int_addr = {R_PEND, 2'b00};
        int_dat_w = 32'h01; int_sel = 4'hf;
        ak = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            if (int_ack) begin
                ak = 1'b1;
                break;
            end
        end
        $display("bus we=1 idx=2 wdata=00000001 with coincident edge on src0 ack=%0b", ak);
        @(negedge clk);
        int_cyc = 1'b0; int_stb = 1'b0; int_we = 1'b0;
        irq_src = 8'h01;
        @(negedge clk);
        irq_src = 8'h00;
        repeat (3) @(posedge clk);
        bus(1'b0, R_PEND, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'h01)
            $display("FAIL w1c_edge_collision: got %h want 00000001", rd);
        else n_pass++;
    endtask

    task automatic test_random();
        int          op;
        logic [7:0]  d;
        logic [7:0]  chg;
        logic [31:0] exp;
        bus(1'b1, R_EN, 32'h00, 4'hf, rd, ak, er);
        bus(1'b1, R_EDGE, 32'h00, 4'hf, rd, ak, er);
        m_pend = '0; m_en = '0; m_edge = '0; m_src = '0;
        for (int it = 0; it < 48; it++) begin
            op = $urandom_range(0, 5);
            d  = 8'($urandom_range(0, 255));
            case (op)
                0: set_src(d);
                1: begin
                    bus(1'b1, R_EN, {24'd0, d}, 4'hf, rd, ak, er);
                    m_en = d;
                end
                2: begin
                    bus(1'b1, R_EDGE, {24'd0, d}, 4'hf, rd, ak, er);
                    chg    = d ^ m_edge;
                    m_edge = d;
                    m_pend = (m_pend & d & ~chg) | (m_src & ~d);
                end
                3: begin
                    bus(1'b1, R_PEND, {24'd0, d}, 4'hf, rd, ak, er);
                    m_pend = m_pend & ~(d & m_edge);
                end
                4: begin
                    exp = 32'd0;
                    for (int i = 0; i < N; i++) begin
                        if (m_pend[i] && m_en[i]) begin
                            exp = i + 1;
                            break;
                        end
                    end
                    bus(1'b0, R_CLAIM, 32'd0, 4'hf, rd, ak, er);
                    n_checks++;
                    if (rd !== exp || ak !== 1'b1)
                        $display("FAIL rand_claim_%0d: got %h ack=%b want %h ack=1", it, rd, ak, exp);
                    else n_pass++;
                    if (exp != 0 && m_edge[exp-1]) m_pend[exp-1] = 1'b0;
                end
                default: begin
                    bus(1'b0, R_PEND, 32'd0, 4'hf, rd, ak, er);
                    n_checks++;
                    if (rd !== {24'd0, m_pend})
                        $display("FAIL rand_pend_%0d: got %h want %h", it, rd, {24'd0, m_pend});
                    else n_pass++;
                end
            endcase
            n_checks++;
            if (external_interrupt !== (|(m_pend & m_en)))
                $display("FAIL rand_ext_%0d: got %b want %b", it, external_interrupt, |(m_pend & m_en));
            else n_pass++;
        end
        set_src(8'h00);
    endtask

    task automatic test_reset_mid();
        bus(1'b1, R_SOFT, 32'd1, 4'hf, rd, ak, er);
        bus(1'b1, R_TIMER, 32'd1, 4'hf, rd, ak, er);
        bus(1'b1, R_EDGE, 32'h00, 4'hf, rd, ak, er);
        bus(1'b1, R_EN, 32'h02, 4'hf, rd, ak, er);
        set_src(8'h02);
        n_checks++;
        if ({external_interrupt, timer_interrupt, software_interrupt} !== 3'b111)
            $display("FAIL pre_reset_outputs: got ext=%b tmr=%b sw=%b want 1 1 1",
                     external_interrupt, timer_interrupt, software_interrupt);
        else n_pass++;
        @(negedge clk);
        int_cyc = 1'b1; int_stb = 1'b1; int_we = 1'b0; int_addr = {R_SOFT, 2'b00}; int_sel = 4'hf;
        @(posedge clk);
        #1;
        n_checks++;
        if (int_ack !== 1'b1 || int_dat_r !== 32'd1)
            $display("FAIL mid_read_ack: got ack=%b data=%h want ack=1 data=00000001", int_ack, int_dat_r);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        $display("bus read idx=0 interrupted by reset ack=%0b", int_ack);
        n_checks++;
        if ({int_ack, int_err, int_dat_r, external_interrupt, timer_interrupt, software_interrupt} !== 37'd0)
            $display("FAIL mid_read_reset: got ack=%b err=%b dat=%h ext=%b tmr=%b sw=%b want all 0",
                     int_ack, int_err, int_dat_r, external_interrupt, timer_interrupt, software_interrupt);
        else n_pass++;
        @(negedge clk);
        int_cyc = 1'b0; int_stb = 1'b0; irq_src = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        bus(1'b0, R_EN, 32'd0, 4'hf, rd, ak, er);
        n_checks++;
        if (rd !== 32'd0 || ak !== 1'b1)
            $display("FAIL post_reset_read: got data=%h ack=%b want data=0 ack=1", rd, ak);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_soft_timer();
        test_back_to_back();
        test_edge_claim();
        test_level();
        test_priority();
        test_w1c_collision();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Parametrised Wishbone-slave interrupt controller; successor to the fixed 3-bit software/timer/external register block.
- Software and timer interrupt bits stay at the same offsets.
- External interrupt becomes an aggregate of N_SRC hardware sources, each with its own enable, edge/level mode, pending bit and a priority claim register.
- Sits beside the core on the data bus and drives the core's three interrupt request lines.

Parameters:
N_SRC, 8, number of external interrupt sources; legal range 1..31.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
int_addr  in  6  byte address; register index = int_addr[5:2]
int_dat_w  in  32  write data
int_sel  in  4  byte selects
int_cyc  in  1  Wishbone cycle
int_stb  in  1  Wishbone strobe
int_cti  in  3  cycle type (ignored)
int_bte  in  2  burst type (ignored)
int_we  in  1  write enable
int_dat_r  out  32  read data, valid in the ack/err cycle
int_ack  out  1  access acknowledge
int_err  out  1  access error
irq_src  in  N_SRC  external interrupt sources
external_interrupt  out  1  OR of (pending & enable)
timer_interrupt  out  1  TIMER register bit 0
software_interrupt  out  1  SOFT register bit 0

Behaviour:
- Reset: all registers 0, int_ack=0, int_err=0, int_dat_r=0, all interrupt outputs 0. The edge-detect history flops reset to 0.
- Handshake:
  - int_cyc & int_stb with neither ack nor err high -> one-cycle response on the next edge: int_ack for mapped indices 0..5, int_err for indices 6..15.
  - Response is never asserted two consecutive cycles, so a held strobe gives a response every other cycle.
  - cti/bte are ignored; every beat is single.
- Writes take effect in the ack cycle, only when int_we=1 and int_sel=4'b1111. Partial writes are acked and ignored. Unused/reserved bits read 0.
- Register map (index: name):
  - 0 SOFT: bit0 RW.
  - 1 TIMER: bit0 RW.
  - 2 PENDING: [N_SRC-1:0] read; write-1-to-clear for edge-mode sources, no effect on level-mode sources.
  - 3 ENABLE: [N_SRC-1:0] RW.
  - 4 EDGE: [N_SRC-1:0] RW; 1=rising edge, 0=level-high.
  - 5 CLAIM: read only; writes are acked and ignored.
- Source sampling (s = sampled irq_src):
  - Level mode: pending[i] = s[i] every cycle.
  - Edge mode: pending[i] set when s[i]=1 and previous s[i]=0; held until cleared.
- Simultaneous events:
  - Edge set and W1C clear of the same bit in the same cycle -> set wins (pending stays 1).
  - Edge set and CLAIM clear in the same cycle -> set wins.
- Writing EDGE clears pending for every bit whose mode changes in that write.
- CLAIM read:
  - Returns k+1, where k is the lowest index with pending[k] & enable[k]; returns 0 if none.
  - Value is computed from register state in the cycle before ack.
  - In the ack cycle, pending[k] is cleared if source k is edge-mode. Level-mode sources are not cleared; software must silence the device.
- external_interrupt = |(pending & enable), registered (one cycle after pending changes). timer_interrupt and software_interrupt are direct register bits.
- Reset mid-transfer: ack/err drop immediately; the transfer is lost and the master must retry.

Optional Feature:
INT_SYNC_EN
- Defined: irq_src passes through a 2-flop synchroniser before sampling; source-to-pending latency is 3 cycles.
- Undefined: irq_src is registered once; latency is 1 cycle; sources must be synchronous to clk.
- Bench latencies are quoted with INT_SYNC_EN undefined.

Test Plan:
- Reset, then read indices 0..5 -> each returns 0 with ack; read index 7 -> int_err=1, int_ack=0, no register change.
- Write SOFT=1 with sel=4'b1111 -> software_interrupt=1 in the cycle after ack. Write TIMER=1 with sel=4'b0011 -> ack, timer_interrupt stays 0.
- N_SRC=8, EDGE=0x08, ENABLE=0x08, pulse irq_src[3] for one cycle:
  - PENDING reads 0x08; external_interrupt=1.
  - CLAIM reads 4, then PENDING reads 0.
  - external_interrupt=0 one cycle later.
- Level source 1 enabled and held high -> CLAIM reads 2 repeatedly and PENDING bit 1 stays set; W1C of 0x02 has no effect; drop source -> pending clears after 1 cycle.
- Sources 2 and 5 edge-pending and enabled -> CLAIM returns 3, then 6, then 0. With source 2 pending but disabled, CLAIM returns 6.
- Edge on irq_src[0] in the same cycle as a W1C write of PENDING=0x01 -> PENDING bit 0 remains 1. Assert rst mid-read -> ack deasserts immediately and all outputs return to 0.
